// File: rtl/cp_ram_pkg.sv
// Shared widths and FSM encoding for the cluster operand RAM and its readers.
package cp_ram_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 72;
    localparam int LEN_W  = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/cp_fifo2.sv
// Two-entry synchronous FIFO of {last, data}; head entry drives the outputs.
module cp_fifo2 #(
    parameter int W = 72
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         push_last,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         head_valid,
    output logic         head_last,
    output logic [W-1:0] head_data,
    output logic [1:0]   occ
);

    logic [1:0][W:0] mem;
    logic            wr_ptr;
    logic            rd_ptr;

    // Caller guarantees push only when not full or popping in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem    <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {push_last, push_data};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head_valid = (occ != 2'd0);
    assign head_last  = mem[rd_ptr][W];
    assign head_data  = mem[rd_ptr][W-1:0];

endmodule

// File: rtl/cp_ram_burst_reader.sv
// Streams a contiguous burst from one operand-RAM read port onto a valid/ready
// stream, covering the RAM's registered-address latency and output backpressure.
module cp_ram_burst_reader
    import cp_ram_pkg::*;
#(
    parameter int ADDR_W = cp_ram_pkg::ADDR_W,
    parameter int DATA_W = cp_ram_pkg::DATA_W,
    parameter int LEN_W  = cp_ram_pkg::LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              done,
    output logic              busy
);

    state_t            state;
    logic [ADDR_W-1:0] addr_cnt;
    logic [LEN_W-1:0]  remaining;

    // s0: address registered, RAM samples it next edge.
    // s1: RAM output carries the word; captured once the FIFO has room.
    logic              s0, s0_last;
    logic              s1, s1_last;

    logic              pop;
    logic              cap;
    logic              issue;
    logic [1:0]        occ;
    logic [2:0]        credit;

    assign pop = out_valid && out_ready;

    // While s1 waits for room, ram_addr is held, so the RAM keeps re-reading
    // the same word and its output acts as a third holding slot.
    assign cap = s1 && ((occ != 2'd2) || pop);

    assign credit = {1'b0, occ} + {2'b00, s0} - {2'b00, pop};
    assign issue  = (state == ISSUE) && (credit < 3'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            ram_addr  <= '0;
            addr_cnt  <= '0;
            remaining <= '0;
            s0        <= 1'b0;
            s0_last   <= 1'b0;
            s1        <= 1'b0;
            s1_last   <= 1'b0;
        end else begin
            done    <= 1'b0;
            s0      <= 1'b0;
            s1      <= s0 | (s1 & ~cap);
            s1_last <= s0 ? s0_last : s1_last;

            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            // The first read issues on the accepting edge.
                            ram_addr  <= cmd_addr;
                            addr_cnt  <= cmd_addr + ADDR_W'(1);
                            remaining <= cmd_len - LEN_W'(1);
                            s0        <= 1'b1;
                            s0_last   <= (cmd_len == LEN_W'(1));
                            state     <= (cmd_len == LEN_W'(1)) ? DRAIN : ISSUE;
                            cmd_ready <= 1'b0;
                            busy      <= 1'b1;
                        end
                    end
                end

                ISSUE: begin
                    if (issue) begin
                        ram_addr  <= addr_cnt;
                        addr_cnt  <= addr_cnt + ADDR_W'(1);
                        remaining <= remaining - LEN_W'(1);
                        s0        <= 1'b1;
                        s0_last   <= (remaining == LEN_W'(1));
                        if (remaining == LEN_W'(1))
                            state <= DRAIN;
                    end
                end

                DRAIN: begin
                    if (pop && out_last) begin
                        state     <= IDLE;
                        done      <= 1'b1;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end

                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    cp_fifo2 #(
        .W(DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cap),
        .push_last (s1_last),
        .push_data (ram_dout),
        .pop       (pop),
        .head_valid(out_valid),
        .head_last (out_last),
        .head_data (out_data),
        .occ       (occ)
    );

endmodule

// File: tb/tb_cp_ram_burst_reader.sv
// Bench for cp_ram_burst_reader: behavioural RAM plus a queue-based reference
// of the words each burst must deliver.
module tb_cp_ram_burst_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_addr;
    logic [10:0] cmd_len;
    logic [9:0]  ram_addr;
    logic [71:0] ram_dout;
    logic        out_valid;
    logic        out_ready;
    logic [71:0] out_data;
    logic        out_last;
    logic        done;
    logic        busy;

    logic [71:0] mem [1024];

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    always @(posedge clk) ram_dout <= mem[ram_addr];

    cp_ram_burst_reader dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_addr (cmd_addr),
        .cmd_len  (cmd_len),
        .ram_addr (ram_addr),
        .ram_dout (ram_dout),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .done     (done),
        .busy     (busy)
    );

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // mode 0: out_ready held high; 1: random 50%; 2: mostly low.
    // abort_after > 0: assert rst once that many beats have been accepted.
    task automatic run_burst(input int addr, input int len, input int mode, input int abort_after);
        logic [71:0] exp_q[$];
        int          idx = 0;
        int          k = 1;
        int          first_k = -1;
        int          last_k = -1;
        int          budget = 50 * len + 30;
        bit          fin = 0;
        bit          prev_stall = 0;
        logic [71:0] prev_data = '0;

        for (int i = 0; i < len; i++) exp_q.push_back(mem[(addr + i) % 1024]);

        @(negedge clk);
        chk("cmd_ready_idle", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_addr  = 10'(addr);
        cmd_len   = 11'(len);
        out_ready = (mode == 0);
        @(negedge clk);
        cmd_valid = 1'b0;

        if (len == 0) begin
            chk("zero_done", done, 1'b1);
            chk("zero_valid", out_valid, 1'b0);
            chk("zero_cmd_ready", cmd_ready, 1'b1);
            chk("zero_busy", busy, 1'b0);
            @(negedge clk);
            chk("zero_done_pulse", done, 1'b0);
            chk("zero_valid2", out_valid, 1'b0);
            return;
        end

        while (!fin && k < budget) begin
            if (abort_after > 0 && idx == abort_after) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("abort_valid", out_valid, 1'b0);
                chk("abort_cmd_ready", cmd_ready, 1'b1);
                chk("abort_busy", busy, 1'b0);
                chk("abort_done", done, 1'b0);
                @(negedge clk);
                chk("abort_done2", done, 1'b0);
                chk("abort_valid2", out_valid, 1'b0);
                return;
            end
            if (k == 1) begin
                chk("busy_rise", busy, 1'b1);
                chk("cmd_ready_low", cmd_ready, 1'b0);
            end
            if (mode == 0 && k <= len)
                chk("ram_addr", ram_addr, 72'((addr + k - 1) % 1024));
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_data", out_data, prev_data);
            end
            if (idx == len) begin
                chk("done_pulse", done, 1'b1);
                chk("busy_fall", busy, 1'b0);
                chk("cmd_ready_back", cmd_ready, 1'b1);
                chk("valid_after", out_valid, 1'b0);
                fin = 1;
            end else begin
                chk("done_low", done, 1'b0);
                if (out_valid && first_k < 0) first_k = k;
                case (mode)
                    0:       out_ready = 1'b1;
                    1:       out_ready = 1'($urandom_range(0, 1));
                    default: out_ready = ($urandom_range(0, 3) == 0);
                endcase
                if (out_valid && out_ready) begin
                    chk("beat_data", out_data, exp_q[idx]);
                    chk("beat_last", out_last, (idx == len - 1));
                    idx++;
                    last_k = k;
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                @(negedge clk);
                k++;
            end
        end
        if (!fin) chk("timeout_beats", 72'(idx), 72'(len + 1));
        if (mode == 0) begin
            chk("first_latency", 72'(first_k), 72'd3);
            chk("last_cycle", 72'(last_k), 72'(len + 2));
        end
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 1024; i++)
            mem[i] = {8'($urandom), 32'($urandom), 32'($urandom)};
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_ram_addr", ram_addr, 10'd0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 72'd0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;

        run_burst(5, 4, 0, 0);
        run_burst(1022, 4, 0, 0);
        run_burst(0, 0, 0, 0);
        run_burst(0, 8, 1, 0);
        run_burst(300, 1, 0, 0);
        run_burst(0, 1024, 0, 0);
        run_burst(7, 10, 0, 3);
        run_burst(100, 2, 0, 0);
        run_burst(1020, 12, 2, 0);
        for (int r = 0; r < 6; r++)
            run_burst(int'($urandom_range(0, 1023)), int'($urandom_range(1, 40)),
                      int'($urandom_range(1, 2)), 0);
        run_burst(50, 3, 0, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
